// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage data memory bus.
// Handshake: the master raises MEM_R_EN and/or MEM_W_EN with addr/wdata
// stable and keeps them there until it samples ready high at a rising edge.
// The access completes at that edge. ready high while idle with no request
// means the memory does not stall the pipeline. rdata is registered and holds
// its value between reads.
interface data_mem_responder_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output MEM_R_EN, MEM_W_EN, addr, wdata, input ready, rdata);
  modport slave  (input MEM_R_EN, MEM_W_EN, addr, wdata, output ready, rdata);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory with IDLE/BUSY/DONE FSM.
// The request is latched in IDLE. It waits WAIT_CYCLES cycles in BUSY and
// completes on the BUSY->DONE edge. Out-of-range accesses drop writes and read
// back 0. Read and write requested together are treated as a write.
// Optional macro DMEM_FAST_EN: IDLE with a request goes straight to DONE and
// performs the access on that edge, so every access takes 2 cycles.
module data_mem_responder #(
  parameter int WAIT_CYCLES = 4,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  data_mem_responder_if.slave        bus,
  output logic [1:0]                 o_state
);
  localparam logic [31:0] BASE_U  = 32'(BASE_ADDR);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_req;
  logic             w_ready;
  logic             w_fire;
  logic             w_busy_done;
  logic             w_acc_write;
  logic             w_in_range;
  logic [31:0]      w_acc_addr;
  logic [31:0]      w_acc_wdata;
  logic [31:0]      w_offset;
  logic [31:0]      w_word;
  logic [IDX_W-1:0] w_index;
  logic [31:0]      r_rdata;
  logic [31:0]      r_mem [DEPTH];

  assign w_req = bus.MEM_R_EN | bus.MEM_W_EN;

`ifdef DMEM_FAST_EN
  // Fast build: the access uses the live request in the IDLE cycle.
  assign w_fire      = (r_state == ST_IDLE) && w_req;
  assign w_busy_done = 1'b1;
  assign w_acc_write = bus.MEM_W_EN;
  assign w_acc_addr  = bus.addr;
  assign w_acc_wdata = bus.wdata;
`else
  localparam int                CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_is_write;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  // Wait counter: loaded on request acceptance, counts down in BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE && w_req) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == ST_BUSY && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Request latch: captures the access in IDLE; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (r_state == ST_IDLE && w_req) begin
      r_is_write <= bus.MEM_W_EN;
      r_addr     <= bus.addr;
      r_wdata    <= bus.wdata;
    end
  end

  assign w_fire      = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_busy_done = (r_cnt == '0);
  assign w_acc_write = r_is_write;
  assign w_acc_addr  = r_addr;
  assign w_acc_wdata = r_wdata;
`endif

  // Address decode: byte offset from the base, low two bits dropped.
  assign w_offset   = w_acc_addr - BASE_U;
  assign w_word     = w_offset >> 2;
  assign w_in_range = (w_acc_addr >= BASE_U) && (w_word < DEPTH_U);
  assign w_index    = w_word[IDX_W-1:0];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state and combinational ready.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = ~w_req;
        if (w_req) begin
`ifdef DMEM_FAST_EN
          w_next = ST_DONE;
`else
          w_next = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        if (w_busy_done) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_ready = 1'b1;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Read data register: loads only when a read completes, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_fire && !w_acc_write) begin
      r_rdata <= w_in_range ? r_mem[w_index] : '0;
    end
  end

  // Storage array: never cleared; a write is suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && w_acc_write && w_in_range) begin
      r_mem[w_index] <= w_acc_wdata;
    end
  end

  assign bus.ready  = w_ready;
  assign bus.rdata  = r_rdata;
  assign o_state    = r_state;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector table, multi-cycle corner sequences
// and randomized accesses against a word-array reference model.
module tb_data_mem_responder;
  localparam int WAIT_CYCLES = 4;
  localparam int DEPTH       = 64;
  localparam int BASE_ADDR   = 1024;
`ifdef DMEM_FAST_EN
  localparam int LAT     = 2;
  localparam int RST_CYC = 1;
`else
  localparam int LAT     = WAIT_CYCLES + 2;
  localparam int RST_CYC = 2;
`endif
  localparam int NVEC = 12;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [NVEC];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE_ADDR);
    return (off >= 0) && ((off / 4) < DEPTH);
  endfunction

  function automatic int model_index(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE_ADDR)) / 4);
  endfunction

  // A combined read+write behaves as a write; reads outside the array give 0.
  task automatic model_apply(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d);
    if (wr) begin
      if (model_in_range(a)) model_mem[model_index(a)] = d;
    end else if (rd) begin
      model_rdata = model_in_range(a) ? model_mem[model_index(a)] : 32'h0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
  endtask

  // Drive one request and wait for ready; returns at the negedge of the
  // completing cycle. Optionally scrambles the inputs while the access waits.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input bit scramble, input bit align,
                            input string name);
    int lat;
    bit done;
    if (align) begin
      @(posedge clk);
      #1;
    end
    bus.MEM_R_EN = rd;
    bus.MEM_W_EN = wr;
    bus.addr     = a;
    bus.wdata    = d;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < LAT + 10) begin
      @(negedge clk);
      lat++;
      if (bus.ready) begin
        done = 1'b1;
      end else if (scramble && lat >= 2) begin
        bus.MEM_R_EN = 1'($urandom);
        bus.MEM_W_EN = 1'($urandom);
        bus.addr     = $urandom;
        bus.wdata    = $urandom;
      end
    end
    check32({name, " latency"}, 32'(lat), 32'(LAT));
    model_apply(rd, wr, a, d);
  endtask

  // Release the bus after completion and compare rdata with the queued value.
  task automatic finish_access(input string name);
    logic [31:0] exp;
    @(posedge clk);
    #1;
    set_idle();
    @(negedge clk);
    exp = exp_q.pop_front();
    check32({name, " ready idle"}, 32'(bus.ready), 32'h1);
    check32({name, " rdata"}, bus.rdata, exp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic        wr;
    int          sel;

    vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'd1280, 32'h12345678, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 1'b0, 32'd1280, 32'h00000000, 32'h00000000};
    vecs[4]  = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 32'h00000000};
    vecs[5]  = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 1'b1, 32'd1032, 32'h55AA55AA, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'h55AA55AA};
    vecs[8]  = '{1'b0, 1'b1, 32'd1028, 32'h11112222, 32'h55AA55AA};
    vecs[9]  = '{1'b1, 1'b0, 32'd1029, 32'h00000000, 32'h11112222};
    vecs[10] = '{1'b0, 1'b1, 32'd1276, 32'hABCD0123, 32'h11112222};
    vecs[11] = '{1'b1, 1'b0, 32'd1278, 32'h00000000, 32'hABCD0123};

    // Reset state
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset ready", 32'(bus.ready), 32'h1);
    check32("reset rdata", bus.rdata, 32'h0);
    check32("reset state", 32'(dbg_state), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rdata = 32'h0;

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1, 1'b1,
                 $sformatf("vec%0d", i));
      exp_q.push_back(vecs[i].exp_rdata);
      finish_access($sformatf("vec%0d", i));
    end

    // Back-to-back reads with the request held high
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b1, "b2b0");
    @(posedge clk);
    #1;
    bus.addr = 32'd1028;
    check32("b2b0 rdata", bus.rdata, 32'hDEADBEEF);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b0, "b2b1");
    exp_q.push_back(32'h11112222);
    finish_access("b2b1");

    // Reset in the middle of a write
    @(posedge clk);
    #1;
    bus.MEM_W_EN = 1'b1;
    bus.addr     = 32'd1028;
    bus.wdata    = 32'hCAFEF00D;
    repeat (RST_CYC) @(posedge clk);
    #1;
    rst = 1'b1;
    set_idle();
    @(posedge clk);
    @(negedge clk);
    check32("rst mid ready", 32'(bus.ready), 32'h1);
    check32("rst mid state", 32'(dbg_state), 32'h0);
    check32("rst mid rdata", bus.rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rdata = 32'h0;
`ifdef DMEM_FAST_EN
    model_apply(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D);
`endif
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b1, "rst readback");
    exp_q.push_back(model_rdata);
    finish_access("rst readback");

    // Fill the whole array so every later read has a known model value
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      run_access(1'b0, 1'b1, 32'(BASE_ADDR + 4 * i), d, 1'($urandom), 1'b1, "fill");
      exp_q.push_back(model_rdata);
      finish_access("fill");
    end

    // Randomized accesses
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel <= 4) || (sel == 9);
      wr  = (sel >= 5);
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, BASE_ADDR - 1));
        1:       a = 32'(BASE_ADDR + 4 * DEPTH) + 32'($urandom_range(0, 100000));
        2:       a = 32'hFFFFFFFC;
        default: a = 32'(BASE_ADDR) + 32'($urandom_range(0, 4 * DEPTH - 1));
      endcase
      d = $urandom;
      run_access(rd, wr, a, d, 1'($urandom), 1'b1, $sformatf("rnd%0d", i));
      exp_q.push_back(model_rdata);
      finish_access($sformatf("rnd%0d", i));
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 4, number of BUSY cycles per access; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 64, number of 32-bit words in the array.
REQ-003 Parameter BASE_ADDR, default 1024, byte address mapped to word 0.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 MEM_R_EN  input  1  read request from the MEM stage.
REQ-008 MEM_W_EN  input  1  write request from the MEM stage.
REQ-009 addr  input  32  byte address, i.e. the ALU result.
REQ-010 wdata  input  32  store data, i.e. the Rm value.
REQ-011 ready  output  1  high means the access completes at this edge and the pipeline may advance; low means freeze.
REQ-012 rdata  output  32  registered read data.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 req is defined as MEM_R_EN | MEM_W_EN.
REQ-015 ready SHALL be combinational: (state==DONE) | (state==IDLE & ~req).
REQ-016 IDLE with req: the block SHALL latch addr, wdata and the operation, load cnt with WAIT_CYCLES-1, and go to BUSY.
REQ-017 BUSY: cnt SHALL decrement each cycle; when cnt==0 the FSM SHALL go to DONE.
REQ-018 DONE: the FSM SHALL return to IDLE unconditionally; a request still present is taken as a new access on the following IDLE cycle.
REQ-019 On the BUSY->DONE edge, a write SHALL store the latched wdata and a read SHALL load rdata.
REQ-020 An access SHALL take WAIT_CYCLES+2 cycles; ready is low for the first WAIT_CYCLES+1 cycles.
REQ-021 Word index SHALL be (addr-BASE_ADDR)>>2; addr[1:0] are ignored.
REQ-022 Out-of-range address (index >= DEPTH or addr < BASE_ADDR): the write SHALL be dropped and the read SHALL return 0.
REQ-023 MEM_R_EN and MEM_W_EN both high: the access SHALL be treated as a write and rdata SHALL be left unchanged.
REQ-024 Inputs changing or deasserting during BUSY SHALL be ignored; the latched request SHALL complete.
REQ-025 rdata SHALL hold its value between reads, including across writes.

Reset
REQ-026 rst SHALL force state=IDLE, cnt=0, rdata=0 and clear the latched request.
REQ-027 Consequently ready SHALL be 1 during reset when req is low.
REQ-028 rst in BUSY or DONE SHALL abort the access, with no array write and no rdata update.
REQ-029 Array contents SHALL NOT be cleared by rst.

Configuration
REQ-030 Macro DMEM_FAST_EN.
REQ-031 With DMEM_FAST_EN defined, IDLE with req SHALL go directly to DONE, performing the array write or rdata load on that edge; WAIT_CYCLES is ignored, and every access takes 2 cycles with ready low in the first.
REQ-032 Without DMEM_FAST_EN, REQ-016 to REQ-020 apply unchanged.

Verification
REQ-033 Write then read, WAIT_CYCLES=4: write addr=1024, wdata=0xDEADBEEF at cycle 0 -> ready low cycles 0-4, high at 5; read of 1024 at cycle 6 -> ready high at 11, rdata=0xDEADBEEF from cycle 12.
REQ-034 Out of range: write addr=1024+4*64 with 0x12345678, then read it -> rdata=0; a read of 1024 still returns 0xDEADBEEF.
REQ-035 Reset mid-access: write 0xCAFEF00D to 1028, rst high at cycle 2 -> state IDLE and ready high at cycle 3 with req low; a later read of 1028 returns the prior value.
REQ-036 R/W both high: write 0x55AA55AA to 1032 with rdata=0xDEADBEEF -> rdata unchanged; a subsequent read of 1032 returns 0x55AA55AA.
REQ-037 Back-to-back reads held high, address 1024 then 1028 -> ready pulses high every 6 cycles, and each rdata matches its word.
REQ-038 With DMEM_FAST_EN: read 1024 -> ready low cycle 0, high cycle 1, rdata=0xDEADBEEF at cycle 2.
